// File: rtl/reg_file_mp_pkg.sv
// reg_file_pkg: default geometry of the multi-port register file and the
// normalised per-port write request shared by the data array and bypass path.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 1;
    localparam int DEF_ZERO_REG = 1;

    // Request fields are sized for the widest supported configuration;
    // narrower instances zero-extend into them.
    localparam int REQ_ADDR_W = 16;
    localparam int REQ_DATA_W = 64;

    typedef struct packed {
        logic                  en;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic req_hits(wr_req_t req, logic [REQ_ADDR_W-1:0] addr);
        return req.en && (req.addr == addr);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write and issue signals of the register file.
// The master side drives addresses/strobes; the slave side returns data/status.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          iss_en;
    logic [ADDR_W-1:0]             iss_addr;
    logic [ADDR_W:0]               busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/reg_file_mp_sb.sv
// reg_file_sb: per-register pending bits set by issue and cleared by write,
// plus a registered population count of the pending set.
module reg_file_sb #(
    parameter int NUM_REGS = 32,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    input  logic                          iss_en,
    input  logic [ADDR_W-1:0]             iss_addr,
    output logic [NUM_REGS-1:0]           pending,
    output logic [ADDR_W:0]               busy_cnt
);

    logic [NUM_REGS-1:0] pend_next;
    logic [ADDR_W:0]     busy_cnt_reg;
    logic [ADDR_W:0]     busy_cnt_next;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign pend_next[gi] = 1'b0;
            assign pending[gi]   = 1'b0;
        end else begin : g_pend
            logic pend_reg;
            logic clr;
            logic set;

            always_comb begin
                clr = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p] == ADDR_W'(gi)) begin
                        clr = 1'b1;
                    end
                end
                set = iss_en && (iss_addr == ADDR_W'(gi));
            end

            // A same-cycle issue outranks the write that would retire the bit.
            assign pend_next[gi] = set | (pend_reg & ~clr);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= pend_next[gi];
                end
            end

            assign pending[gi] = pend_reg;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W+1)'(pend_next[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_reg <= '0;
        end else begin
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with an issue/write pending scoreboard.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_mp_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    wr_req_t             wr_req [NUM_WR];
    logic [DATA_W-1:0]   reg_q  [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [ADDR_W:0]     busy_cnt;
    logic [NUM_WR-1:0]   unused_req;

    // Effective requests: writes to the hardwired zero register and anything
    // presented while reset is held never take effect, even through bypass.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_req[p].addr = REQ_ADDR_W'(bus.wr_addr[p]);
            wr_req[p].data = REQ_DATA_W'(bus.wr_data[p]);
            wr_req[p].en   = bus.wr_en[p] && !reset &&
                             !(ZERO_REG != 0 && bus.wr_addr[p] == '0);
        end
    end

    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_req_sink
        assign unused_req[gi] = ^wr_req[gi];
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign reg_q[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;

            // Ports are scanned in ascending order so the highest port wins.
            always_comb begin
                data_next = data_reg;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (req_hits(wr_req[p], REQ_ADDR_W'(gi))) begin
                        data_next = wr_req[p].data[DATA_W-1:0];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else begin
                    data_reg <= data_next;
                end
            end

            assign reg_q[gi] = data_reg;
        end
    end

    reg_file_sb #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .pending  (pending),
        .busy_cnt (busy_cnt)
    );

    assign bus.busy_cnt = busy_cnt;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_data_next;
        logic              rd_busy_next;

        assign ra = bus.rd_addr[gi];

        always_comb begin
            rd_data_next = reg_q[ra];
            rd_busy_next = pending[ra];
`ifdef REG_FILE_MP_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
                if (req_hits(wr_req[p], REQ_ADDR_W'(ra))) begin
                    rd_data_next = wr_req[p].data[DATA_W-1:0];
                    if (!(bus.iss_en && bus.iss_addr == ra)) begin
                        rd_busy_next = 1'b0;
                    end
                end
            end
`endif
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data_next = '0;
            end
        end

        assign bus.rd_data[gi] = rd_data_next;
        assign bus.rd_busy[gi] = rd_busy_next;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table, hand sequences for bypass and
// mid-cycle reset, then randomized traffic checked against a reference model.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    reg_file_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        bit            we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        bit            iss;
        logic [AW-1:0] ia;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] ex_d0;
        logic [DW-1:0] ex_d1;
        logic [1:0]    ex_busy;
        logic [AW:0]   ex_cnt;
    } vec_t;

    vec_t tbl [12];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: architectural register contents and the pending set.
    logic [DW-1:0] m_mem  [NR];
    bit            m_pend [NR];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void m_clear();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] m_rd(logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (BYP) begin
            for (int p = 0; p < NWR; p++)
                if (bus.wr_en[p] && bus.wr_addr[p] == a) v = bus.wr_data[p];
        end
        return v;
    endfunction

    function automatic bit m_busy(logic [AW-1:0] a);
        bit b;
        b = m_pend[a];
        if (BYP && !(bus.iss_en && bus.iss_addr == a)) begin
            for (int p = 0; p < NWR; p++)
                if (bus.wr_en[p] && bus.wr_addr[p] == a) b = 1'b0;
        end
        return b;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic void m_commit();
        for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p]) begin
                m_pend[bus.wr_addr[p]] = 1'b0;
                if (bus.wr_addr[p] != 0) m_mem[bus.wr_addr[p]] = bus.wr_data[p];
            end
        end
        if (bus.iss_en && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
    endfunction

    task automatic drive(bit we0, logic [AW-1:0] wa0, logic [DW-1:0] wd0,
                         bit we1, logic [AW-1:0] wa1, logic [DW-1:0] wd1,
                         bit iss, logic [AW-1:0] ia,
                         logic [AW-1:0] ra0, logic [AW-1:0] ra1);
        bus.wr_en      = {we1, we0};
        bus.wr_addr[0] = wa0;
        bus.wr_data[0] = wd0;
        bus.wr_addr[1] = wa1;
        bus.wr_data[1] = wd1;
        bus.iss_en     = iss;
        bus.iss_addr   = ia;
        bus.rd_addr[0] = ra0;
        bus.rd_addr[1] = ra1;
    endtask

    task automatic clock_commit();
        @(posedge clk);
        if (!reset) m_commit();
        #1;
    endtask

    task automatic vec_step(string name, vec_t v);
        drive(v.we0, v.wa0, v.wd0, v.we1, v.wa1, v.wd1, v.iss, v.ia, v.ra0, v.ra1);
        #3;
        chk($sformatf("%s.rd_data0", name), bus.rd_data[0], v.ex_d0);
        chk($sformatf("%s.rd_data1", name), bus.rd_data[1], v.ex_d1);
        chk($sformatf("%s.rd_busy0", name), bus.rd_busy[0], v.ex_busy[0]);
        chk($sformatf("%s.rd_busy1", name), bus.rd_busy[1], v.ex_busy[1]);
        chk($sformatf("%s.busy_cnt", name), bus.busy_cnt, v.ex_cnt);
        $display("%s: we=%b iss=%b/%0d rd=%0d,%0d -> d=0x%0h,0x%0h busy=%b cnt=%0d",
                 name, bus.wr_en, v.iss, v.ia, v.ra0, v.ra1,
                 bus.rd_data[0], bus.rd_data[1], bus.rd_busy, bus.busy_cnt);
        clock_commit();
    endtask

    task automatic model_step(int idx);
        #3;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rnd%0d.rd_data%0d", idx, i), bus.rd_data[i], m_rd(bus.rd_addr[i]));
            chk($sformatf("rnd%0d.rd_busy%0d", idx, i), bus.rd_busy[i], m_busy(bus.rd_addr[i]));
        end
        chk($sformatf("rnd%0d.busy_cnt", idx), bus.busy_cnt, m_cnt());
        $display("rnd%0d: we=%b wa=%0d,%0d iss=%b/%0d rd=%0d,%0d cnt=%0d",
                 idx, bus.wr_en, bus.wr_addr[0], bus.wr_addr[1], bus.iss_en,
                 bus.iss_addr, bus.rd_addr[0], bus.rd_addr[1], bus.busy_cnt);
        clock_commit();
    endtask

    initial begin
        //            we0 wa0   wd0            we1 wa1   wd1       iss ia    ra0   ra1    d0             d1             busy   cnt
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd1, 5'd2, 32'h0,        32'h0,        2'b00, 6'd0};
        tbl[1]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
        tbl[2]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd7, 5'd3, 32'h22,       32'h0,        2'b00, 6'd0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        2'b01, 6'd1};
        tbl[5]  = '{1'b1, 5'd3, 32'h99,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd7, 32'h0,        32'h22,       2'b01, 6'd2};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h99,       32'h0,        2'b10, 6'd1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00, 6'd1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 5'd4, 5'd3, 32'h0,        32'h99,       2'b01, 6'd2};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd9, 5'd0, 32'hAA,       32'h0,        2'b01, 6'd2};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 5'd9, 5'd0, 32'hAA,       32'h0,        2'b01, 6'd2};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd9, 32'h0,        32'hAA,       2'b11, 6'd2};

        // Reset with write and issue traffic held: nothing may stick.
        reset = 1'b1;
        m_clear();
        drive(1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 5'd6, 32'hFFFF, 1'b1, 5'd5, 5'd5, 5'd6);
        #1;
        chk("reset.rd_data0", bus.rd_data[0], 0);
        chk("reset.busy_cnt", bus.busy_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        #3;
        chk("post_reset.rd_data0", bus.rd_data[0], 0);
        chk("post_reset.rd_data1", bus.rd_data[1], 0);
        chk("post_reset.rd_busy", bus.rd_busy, 0);
        chk("post_reset.busy_cnt", bus.busy_cnt, 0);
        clock_commit();

        for (int i = 0; i < 12; i++) vec_step($sformatf("vec%0d", i), tbl[i]);

        // Same-cycle write/read of a pending register: bypass-dependent.
        vec_step("byp_iss", '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 5'd9,
                              32'h0, 32'hAA, 2'b10, 6'd2});
        vec_step("byp_wr",  '{1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd2,
                              BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0,
                              BYP ? 2'b00 : 2'b11, 6'd3});
        vec_step("byp_rd",  '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd4,
                              32'h55, 32'h0, 2'b10, 6'd2});
        vec_step("pre_rst", '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9,
                              32'h99, 32'hAA, 2'b10, 6'd2});

        // Mid-cycle reset with x3/x4/x9 pending: clears before the next edge.
        drive(1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd3, 5'd9);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.rd_data0", bus.rd_data[0], 0);
        chk("midrst.rd_data1", bus.rd_data[1], 0);
        chk("midrst.rd_busy", bus.rd_busy, 0);
        chk("midrst.busy_cnt", bus.busy_cnt, 0);
        $display("midrst: d=0x%0h,0x%0h busy=%b cnt=%0d",
                 bus.rd_data[0], bus.rd_data[1], bus.rd_busy, bus.busy_cnt);
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd3);
        model_step(-1);

        for (int c = 0; c < 500; c++) begin
            int unsigned lim;
            lim = (c % 4 == 0) ? 31 : 7;
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, lim)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, lim)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, lim)),
                  AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim)));
            model_step(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter NUM_REGS, default 32, register count (power of 2, >=2); ADDR_W = log2(NUM_REGS).
REQ-003 SHALL provide parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter NUM_WR, default 1, number of write ports (1..2).
REQ-005 SHALL provide parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 rd_addr  in  NUM_RD x ADDR_W  read addresses.
REQ-009 rd_data  out  NUM_RD x DATA_W  read data, combinational.
REQ-010 rd_busy  out  NUM_RD  pending-write flag of addressed register, combinational.
REQ-011 wr_en  in  NUM_WR  per-port write strobe.
REQ-012 wr_addr  in  NUM_WR x ADDR_W  write addresses.
REQ-013 wr_data  in  NUM_WR x DATA_W  write data.
REQ-014 iss_en  in  1  issue strobe: destination register marked pending.
REQ-015 iss_addr  in  ADDR_W  destination register being issued.
REQ-016 busy_cnt  out  ADDR_W+1  number of registers currently pending.

Function
REQ-017 Write SHALL commit on the rising clk edge when wr_en[p]=1; register 0 never written when ZERO_REG=1.
REQ-018 Two write ports, same address, same cycle: port NUM_WR-1 SHALL win; lower port discarded.
REQ-019 rd_data[i] SHALL be 0 when ZERO_REG=1 and rd_addr[i]=0, regardless of bypass.
REQ-020 Scoreboard: per-register pending bit; iss_en sets bit iss_addr at next edge; any wr_en to that address clears it at next edge.
REQ-021 iss_en and wr_en to same address in same cycle: pending bit SHALL end set (new issue wins); data still written.
REQ-022 iss_en to register 0 with ZERO_REG=1 SHALL be ignored; register 0 never pending.
REQ-023 iss_en to an already-pending register SHALL leave it pending; busy_cnt unchanged.
REQ-024 rd_busy[i] SHALL reflect pending bit registered state (no same-cycle clear visibility unless bypass compiled in).
REQ-025 busy_cnt SHALL equal population count of pending bits, updated registered in same edge as bits (saturates naturally at NUM_REGS-ZERO_REG).

Reset
REQ-026 reset=1 SHALL asynchronously clear all registers to 0, all pending bits to 0, busy_cnt to 0.
REQ-027 Write, issue, or bypass asserted during reset SHALL have no effect; first commit on first edge after deassertion.

Configuration
REQ-028 Macro REG_FILE_MP_BYPASS_EN defined: rd_data[i] SHALL return wr_data of the winning port when wr_en matches rd_addr[i] in the same cycle, and rd_busy[i] SHALL read 0 for that address unless iss_en also targets it.
REQ-029 Macro undefined: rd_data returns stored value only (new value visible cycle after write); rd_busy per REQ-024.

Structure
REQ-030 Package reg_file_pkg SHALL hold default parameter constants and a typedef for the per-port write request (en, addr, data).
REQ-031 Sub-module reg_file_sb (scoreboard: pending bits, busy_cnt) SHALL be instantiated once; data array and read mux stay in reg_file_mp.

Verification
REQ-032 Reset, write x5=0xDEADBEEF, read x5 next cycle -> rd_data=0xDEADBEEF; write x0=0x1234 -> rd_data for x0 =0.
REQ-033 NUM_WR=2, both ports write x7 (0x11, 0x22) same cycle -> x7=0x22.
REQ-034 iss x3, then iss x4 -> busy_cnt 1 then 2, rd_busy x3=1; write x3 -> busy_cnt=1, rd_busy x3=0.
REQ-035 iss x9 and write x9=0xAA same cycle with x9 pending -> x9 stays pending, busy_cnt unchanged, x9=0xAA.
REQ-036 With BYPASS_EN: write x2=0x55 and read x2 same cycle -> rd_data=0x55; without: old value, 0x55 next cycle.
REQ-037 Pending x3, x4 and x3=0x99, assert reset mid-cycle -> all reads 0, busy_cnt=0 immediately, before next edge.
